// File: rtl/pmem_dpi_port.sv
// Single-port physical-memory model: valid/ready request/response, LATENCY-cycle access,
// 32/64-bit data. Optional misalignment errors via `PMEM_DPI_ALIGN_CHECK_EN`.
`timescale 1ns/1ps
module pmem_dpi_port #(
  parameter int DATA_W  = 32,
  parameter int LATENCY = 1
) (
  input  logic                clk,
  input  logic                resetn,
  input  logic                req_valid,
  output logic                req_ready,
  input  logic                req_wen,
  input  logic [31:0]         req_addr,
  input  logic [DATA_W-1:0]   req_wdata,
  input  logic [DATA_W/8-1:0] req_wmask,
  output logic                resp_valid,
  input  logic                resp_ready,
  output logic [DATA_W-1:0]   resp_rdata,
  output logic                resp_err
);

  localparam int NB    = DATA_W / 8;
  localparam int AW    = $clog2(NB);
  localparam int WORDS = DATA_W / 32;
  localparam int CW    = (LATENCY < 2) ? 1 : $clog2(LATENCY + 1);

  if (!(DATA_W == 32 || DATA_W == 64) || LATENCY < 1) begin : g_bad_param
    $error("pmem_dpi_port: DATA_W must be 32/64 and LATENCY >= 1");
  end

  typedef struct packed {
    logic              wen;
    logic [31:0]       addr;
    logic [DATA_W-1:0] wdata;
    logic [NB-1:0]     wmask;
  } req_t;

  typedef struct packed {
    logic              err;
    logic [DATA_W-1:0] rdata;
  } resp_t;

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

  // Word-addressed sparse store with call counters, same contract as the C model.
  int unsigned mem [int unsigned];
  int unsigned rd_calls;
  int unsigned wr_calls;

  function automatic int unsigned pmem_read(input int unsigned raddr);
    int unsigned k;
    k = raddr & ~32'h3;
    rd_calls++;
    return mem.exists(k) ? mem[k] : 32'h0;
  endfunction

  function automatic void pmem_write(input int unsigned waddr, input int unsigned wdata,
                                     input byte unsigned wmask);
    int unsigned k, v;
    k = waddr & ~32'h3;
    v = mem.exists(k) ? mem[k] : 32'h0;
    for (int b = 0; b < 4; b++)
      if (wmask[b]) v[b*8 +: 8] = wdata[b*8 +: 8];
    mem[k] = v;
    wr_calls++;
  endfunction

  // Performs the memory side effect; called only on the edge entering RESP.
  function automatic resp_t access(input req_t q);
    resp_t       r;
    logic [31:0] a;
    r = '0;
`ifdef PMEM_DPI_ALIGN_CHECK_EN
    if (|q.addr[AW-1:0]) begin
      r.err = 1'b1;
      return r;
    end
    a = q.addr;
`else
    a = {q.addr[31:AW], {AW{1'b0}}};
`endif
    if (q.wen) begin
      if (|q.wmask)
        for (int w = 0; w < WORDS; w++)
          pmem_write(a + 32'(w * 4), q.wdata[w*32 +: 32], {4'b0, q.wmask[w*4 +: 4]});
    end else begin
      for (int w = 0; w < WORDS; w++)
        r.rdata[w*32 +: 32] = pmem_read(a + 32'(w * 4));
    end
    return r;
  endfunction

  state_t        state;
  logic [CW-1:0] cnt;
  req_t          held;
  req_t          req_in;
  resp_t         rsp_q;

  assign req_in     = {req_wen, req_addr, req_wdata, req_wmask};
  assign resp_rdata = rsp_q.rdata;
  assign resp_err   = rsp_q.err;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state      <= S_IDLE;
      cnt        <= '0;
      held       <= '0;
      rsp_q      <= '0;
      req_ready  <= 1'b0;
      resp_valid <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (req_ready && req_valid) begin
            held      <= req_in;
            req_ready <= 1'b0;
            if (LATENCY == 1) begin
              // Latch regs are not yet loaded, so the access uses the live request.
              rsp_q      <= access(req_in);
              resp_valid <= 1'b1;
              state      <= S_RESP;
            end else begin
              cnt   <= CW'(LATENCY - 1);
              state <= S_WAIT;
            end
          end else begin
            req_ready <= 1'b1;
          end
        end
        S_WAIT: begin
          if (cnt == CW'(1)) begin
            cnt        <= '0;
            rsp_q      <= access(held);
            resp_valid <= 1'b1;
            state      <= S_RESP;
          end else begin
            cnt <= cnt - CW'(1);
          end
        end
        S_RESP: begin
          if (resp_ready) begin
            resp_valid <= 1'b0;
            req_ready  <= 1'b1;
            state      <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_pmem_dpi_port.sv
// Directed bench for pmem_dpi_port: three instances (32/L3, 64/L1, 32/L4) share clk/resetn.
`timescale 1ns/1ps
module tb_pmem_dpi_port;

  logic clk = 1'b0;
  logic resetn;
  always #5 clk = ~clk;

  logic [2:0]  rv, wen, pr;
  logic [31:0] addr [3];
  logic [63:0] wd   [3];
  logic [7:0]  wm   [3];
  wire  [2:0]  rr, pv, er;
  wire  [31:0] rd_a, rd_c;
  wire  [63:0] rd_b;

  int n_tests = 0;
  int n_fail  = 0;

  pmem_dpi_port #(.DATA_W(32), .LATENCY(3)) u_a (
    .clk(clk), .resetn(resetn), .req_valid(rv[0]), .req_ready(rr[0]), .req_wen(wen[0]),
    .req_addr(addr[0]), .req_wdata(wd[0][31:0]), .req_wmask(wm[0][3:0]),
    .resp_valid(pv[0]), .resp_ready(pr[0]), .resp_rdata(rd_a), .resp_err(er[0]));

  pmem_dpi_port #(.DATA_W(64), .LATENCY(1)) u_b (
    .clk(clk), .resetn(resetn), .req_valid(rv[1]), .req_ready(rr[1]), .req_wen(wen[1]),
    .req_addr(addr[1]), .req_wdata(wd[1]), .req_wmask(wm[1]),
    .resp_valid(pv[1]), .resp_ready(pr[1]), .resp_rdata(rd_b), .resp_err(er[1]));

  pmem_dpi_port #(.DATA_W(32), .LATENCY(4)) u_c (
    .clk(clk), .resetn(resetn), .req_valid(rv[2]), .req_ready(rr[2]), .req_wen(wen[2]),
    .req_addr(addr[2]), .req_wdata(wd[2][31:0]), .req_wmask(wm[2][3:0]),
    .resp_valid(pv[2]), .resp_ready(pr[2]), .resp_rdata(rd_c), .resp_err(er[2]));

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [63:0] rd_of(input int i);
    case (i)
      0:       return {32'h0, rd_a};
      1:       return rd_b;
      default: return {32'h0, rd_c};
    endcase
  endfunction

  // One request on instance i with resp_ready=1; lat = cycles from acceptance to resp_valid.
  // Called and returns at a negedge.
  task automatic xact(input int i, input logic w, input logic [31:0] ad, input logic [63:0] d,
                      input logic [7:0] m, output logic [63:0] rdat, output logic e,
                      output int lat);
    int t;
    t = 0; rdat = '0; e = 1'b0; lat = -1;
    while (!rr[i] && t < 50) begin @(negedge clk); t++; end
    if (!rr[i]) begin chk("req_ready_timeout", {63'h0, rr[i]}, 64'h1); return; end
    rv[i] = 1'b1; wen[i] = w; addr[i] = ad; wd[i] = d; wm[i] = m; pr[i] = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rv[i] = 1'b0;
    lat = 1;
    while (!pv[i] && lat < 50) begin @(negedge clk); lat++; end
    if (!pv[i]) begin chk("resp_valid_timeout", {63'h0, pv[i]}, 64'h1); return; end
    rdat = rd_of(i);
    e    = er[i];
    @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [63:0] d;
    logic        e, seen;
    int          lat;
    int unsigned c0;

    rv = '0; wen = '0; pr = '0;
    for (int i = 0; i < 3; i++) begin addr[i] = '0; wd[i] = '0; wm[i] = '0; end
    resetn = 1'b1;
    #2 resetn = 1'b0;

    // Reset state, then req_ready one edge after release
    repeat (3) begin
      @(negedge clk);
      chk("rst_req_ready", {61'h0, rr}, 64'h0);
      chk("rst_resp_valid", {61'h0, pv}, 64'h0);
      chk("rst_resp_err", {61'h0, er}, 64'h0);
      chk("rst_rdata", {rd_a, rd_c} | rd_b, 64'h0);
    end
    resetn = 1'b1;
    chk("ready_before_edge", {61'h0, rr}, 64'h0);
    @(negedge clk);
    chk("ready_after_edge", {61'h0, rr}, 64'h7);

    // 32-bit, LATENCY=3 read latency
    xact(0, 1'b1, 32'h8000_0000, 64'hDEAD_BEEF, 8'hF, d, e, lat);
    chk("a_wr_lat", lat, 3);
    chk("a_wr_rdata", d, 64'h0);
    c0 = u_a.rd_calls;
    xact(0, 1'b0, 32'h8000_0000, 64'h0, 8'h0, d, e, lat);
    chk("a_rd_lat", lat, 3);
    chk("a_rd_data", d, 64'hDEAD_BEEF);
    chk("a_rd_err", {63'h0, e}, 64'h0);
    chk("a_rd_calls", u_a.rd_calls - c0, 1);

    // Partial and zero byte masks
    xact(0, 1'b1, 32'h8000_0004, 64'hAABB_CCDD, 8'hF, d, e, lat);
    xact(0, 1'b1, 32'h8000_0004, 64'h1122_3344, 8'h6, d, e, lat);
    c0 = u_a.wr_calls;
    xact(0, 1'b1, 32'h8000_0004, 64'hFFFF_FFFF, 8'h0, d, e, lat);
    chk("a_zero_mask_calls", u_a.wr_calls - c0, 0);
    chk("a_zero_mask_lat", lat, 3);
    xact(0, 1'b0, 32'h8000_0004, 64'h0, 8'h0, d, e, lat);
    chk("a_mask_merge", d, 64'hAA22_33DD);

    // 64-bit, LATENCY=1 masked write then read
    xact(1, 1'b1, 32'h8000_0000, 64'h0, 8'hFF, d, e, lat);
    chk("b_wr_lat", lat, 1);
    c0 = u_b.wr_calls;
    xact(1, 1'b1, 32'h8000_0000, 64'h1122_3344_5566_7788, 8'h0F, d, e, lat);
    chk("b_wr_calls", u_b.wr_calls - c0, 2);
    c0 = u_b.rd_calls;
    xact(1, 1'b0, 32'h8000_0000, 64'h0, 8'h0, d, e, lat);
    chk("b_rd_lat", lat, 1);
    chk("b_rd_data", d, 64'h0000_0000_5566_7788);
    chk("b_rd_calls", u_b.rd_calls - c0, 2);
    xact(1, 1'b0, 32'h8000_0004, 64'h0, 8'h0, d, e, lat);
`ifdef PMEM_DPI_ALIGN_CHECK_EN
    chk("b_misalign_err", {63'h0, e}, 64'h1);
    chk("b_misalign_data", d, 64'h0);
`else
    chk("b_misalign_err", {63'h0, e}, 64'h0);
    chk("b_aligned_down", d, 64'h0000_0000_5566_7788);
`endif

    // Back-pressure on A with a second request held during RESP
    xact(0, 1'b1, 32'h8000_0008, 64'h0BAD_F00D, 8'hF, d, e, lat);
    rv[0] = 1'b1; wen[0] = 1'b0; addr[0] = 32'h8000_0008; pr[0] = 1'b0;
    @(posedge clk);
    @(negedge clk);
    addr[0] = 32'h8000_0000;
    lat = 1;
    while (!pv[0] && lat < 50) begin
      chk("bp_ready_in_wait", {63'h0, rr[0]}, 64'h0);
      @(negedge clk);
      lat++;
    end
    chk("bp_lat", lat, 3);
    repeat (5) begin
      chk("bp_valid_held", {63'h0, pv[0]}, 64'h1);
      chk("bp_rdata_held", {32'h0, rd_a}, 64'h0BAD_F00D);
      chk("bp_ready_in_resp", {63'h0, rr[0]}, 64'h0);
      @(negedge clk);
    end
    pr[0] = 1'b1;
    @(negedge clk);
    chk("bp_valid_dropped", {63'h0, pv[0]}, 64'h0);
    chk("bp_ready_back", {63'h0, rr[0]}, 64'h1);
    @(posedge clk);
    @(negedge clk);
    rv[0] = 1'b0;
    lat = 1;
    while (!pv[0] && lat < 50) begin @(negedge clk); lat++; end
    chk("bp_second_lat", lat, 3);
    chk("bp_second_data", {32'h0, rd_a}, 64'hDEAD_BEEF);
    @(negedge clk);

    // Reset two cycles into a LATENCY=4 write
    xact(2, 1'b1, 32'h8000_0000, 64'h0123_4567, 8'hF, d, e, lat);
    chk("c_wr_lat", lat, 4);
    c0 = u_c.wr_calls;
    rv[2] = 1'b1; wen[2] = 1'b1; addr[2] = 32'h8000_0000; wd[2] = 64'hFFFF_FFFF; wm[2] = 8'hF;
    pr[2] = 1'b1;
    @(posedge clk);
    #1 rv[2] = 1'b0;
    repeat (2) @(posedge clk);
    #1 resetn = 1'b0;
    @(negedge clk);
    chk("c_rst_valid", {63'h0, pv[2]}, 64'h0);
    chk("c_rst_ready", {63'h0, rr[2]}, 64'h0);
    @(negedge clk);
    resetn = 1'b1;
    seen = 1'b0;
    repeat (8) begin @(negedge clk); seen |= pv[2]; end
    chk("c_no_response", {63'h0, seen}, 64'h0);
    chk("c_no_write_call", u_c.wr_calls - c0, 0);
    xact(2, 1'b0, 32'h8000_0000, 64'h0, 8'h0, d, e, lat);
    chk("c_mem_unchanged", d, 64'h0123_4567);

    // Misaligned 32-bit read
    c0 = u_a.rd_calls;
    xact(0, 1'b0, 32'h8000_0002, 64'h0, 8'h0, d, e, lat);
    chk("a_misalign_lat", lat, 3);
`ifdef PMEM_DPI_ALIGN_CHECK_EN
    chk("a_misalign_err", {63'h0, e}, 64'h1);
    chk("a_misalign_data", d, 64'h0);
    chk("a_misalign_calls", u_a.rd_calls - c0, 0);
`else
    chk("a_misalign_err", {63'h0, e}, 64'h0);
    chk("a_misalign_data", d, 64'hDEAD_BEEF);
    chk("a_misalign_calls", u_a.rd_calls - c0, 1);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
